// File: rtl/passma_tx.sv
// Password-sequence transmitter: plays a latched 4-key code on the keypad bus.
// Each key is held HOLD cycles, then released to 0000 for GAP cycles.
module passma_tx #(
  parameter int HOLD = 2,
  parameter int GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] keys,
  output logic [3:0]  pass,
  output logic        busy,
  output logic        done,
  output logic [1:0]  idx
);

  localparam int MX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] HL = CW'(HOLD - 1);
  localparam logic [CW-1:0] GL = CW'(GAP - 1);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx_n;
  logic [15:0]   key_q, key_n;
  logic [3:0]    pass_n;
  logic          busy_n, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      key_q <= '0;
      pass  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      key_q <= key_n;
      pass  <= pass_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    key_n   = key_q;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = PRESS;
          cnt_n   = '0;
          idx_n   = '0;
          key_n   = keys;
        end
      end
      PRESS: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end else if (cnt == HL) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RELEASE: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end else if (cnt == GL) begin
          cnt_n = '0;
          if (idx == 2'd3) begin
            state_n = DONE;
          end else begin
            state_n = PRESS;
            idx_n   = idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    pass_n = 4'h0;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state_n)
      PRESS: begin
        busy_n = 1'b1;
        case (idx_n)
          2'd0:    pass_n = key_n[3:0];
          2'd1:    pass_n = key_n[7:4];
          2'd2:    pass_n = key_n[11:8];
          default: pass_n = key_n[15:12];
        endcase
      end
      RELEASE: busy_n = 1'b1;
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/passma_tx.md
# passma_tx

Password-sequence transmitter: the driving end of the 4-bit keypad password interface. On a `start` request it plays out a 4-key code sequence on `pass`. Each key is held for `HOLD` cycles, then released to `4'b0000` for `GAP` cycles, so the downstream lock sees a code followed by a release for every key. It sits between the test/control logic and the `pass` input of the password lock, and replaces manual keypad entry in system-level runs.

## Interface
- `HOLD`, default 2: cycles each key code is driven on `pass`; legal range ≥ 1.
- `GAP`, default 2: cycles of `4'b0000` driven after each key; legal range ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-high. Clears all state immediately.
- `start`  in  1  request to transmit; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of an in-progress transmission.
- `keys`  in  16  key sequence. Key k is `keys[4k+3:4k]`, and key 0 is sent first. The lock sequence 0111, 1100, 0010, 1110 is `16'hE2C7`.
- `pass`  out  4  registered keypad code to the lock.
- `busy`  out  1  high while a sequence is being played out.
- `done`  out  1  one-cycle pulse after the last release completes normally.
- `idx`  out  2  index of the key currently being pressed or released.

## Operation
- States: IDLE, PRESS, RELEASE, DONE. The state, a 2-bit key index, a cycle counter (width `$clog2(max(HOLD,GAP))+1`) and a 16-bit key latch are all registered.
- Reset values: `pass=0000`, `busy=0`, `done=0`, `idx=0`, state IDLE, counter 0.
- IDLE:
  - `pass=0000`, `busy=0`.
  - `start=1 && abort=0`: latch `keys`, set idx=0, go to PRESS, counter=0.
- PRESS:
  - `pass` = latched key[idx], `busy=1`.
  - After `HOLD` cycles in PRESS, go to RELEASE with counter=0.
- RELEASE:
  - `pass=0000`, `busy=1`.
  - After `GAP` cycles in RELEASE: if idx=3, go to DONE; else idx+1 and go to PRESS.
- DONE:
  - `done=1`, `busy=0`, `pass=0000` for exactly one cycle, then IDLE.
  - `start` in DONE is ignored.
- `keys` is latched only at start acceptance. Changes to `keys` while busy do not affect the sequence in flight.
- `start` while busy or in DONE is ignored. It is not queued.
- `abort=1` in PRESS or RELEASE: the next cycle is IDLE with `pass=0000`, `busy=0`, `idx=0`, and no `done` pulse.
- `abort` in IDLE or DONE has no effect, except that it blocks a simultaneous `start` in IDLE. `abort` always has priority over `start`.
- A key value of `0000` is transmitted as-is: `pass` stays `0000` through its PRESS window, and the timing is unchanged.
- `rst` asserted mid-sequence returns all outputs to reset values asynchronously. No `done` is produced.

## Timing
- All outputs are registered. No combinational path runs from any input to any output.
- Let cycle 0 be the edge where `start` is sampled. Key 0 appears on `pass` and `busy` rises after edge 0, i.e. during cycle 1.
- Key k is on `pass` during cycles `k*(HOLD+GAP)+1` through `k*(HOLD+GAP)+HOLD`. `0000` follows for the next `GAP` cycles.
- `busy` is high for exactly `4*(HOLD+GAP)` cycles.
- `done` is high in cycle `4*(HOLD+GAP)+1`. IDLE resumes in the following cycle, and a new `start` is accepted there at the earliest.
- Back-to-back transmissions are spaced at a minimum of `4*(HOLD+GAP)+2` cycles between `start` samples.
- Every code→`0000` transition lasts at least one cycle on each side. This is sufficient for a lock that compares the previous and current sampled codes on the same clock.
- `idx` changes on the RELEASE→PRESS edge and returns to 0 on entry to IDLE.

## Test plan
- Nominal (HOLD=2, GAP=2, `keys=16'hE2C7`), `start` pulse at cycle 0:
  - `pass` is 0111 in cycles 1–2, 0000 in 3–4, 1100 in 5–6, 0000 in 7–8, 0010 in 9–10, 0000 in 11–12, 1110 in 13–14, 0000 in 15–16.
  - `busy` is high in cycles 1–16, `done=1` in cycle 17.
  - With the password lock connected, its `led` reaches `1111`.
- Minimum timing (HOLD=1, GAP=1, `keys=16'hE2C7`): `pass` alternates code/`0000` every cycle over cycles 1–8, `done` is high in cycle 9, and the lock still reaches `led=1111`.
- `start` re-asserted in cycles 3 and 17 (DONE), and `keys` changed to `16'h0000` in cycle 4: the sequence is unchanged from the nominal case and no second transmission starts. A `start` in cycle 18 is accepted.
- `abort` in cycle 6 (key 1 pressed): cycle 7 shows `pass=0000`, `busy=0`, `idx=0`. `done` never pulses, and the lock `led` stays at `0001`.
- `abort` and `start` together in IDLE: nothing starts. `rst` asserted in cycle 9: `pass`, `busy`, `done` and `idx` go to 0 immediately, with no `done` pulse.
- `keys=16'h0000`: `pass` stays `0000` throughout, `busy` is high for 16 cycles (HOLD=GAP=2), `done` is high in cycle 17, and the lock `led` stays at `0000`.
